// File: rtl/sha256_padder.sv
// Streams an N-word message from memory followed by SHA-256 padding and the
// 64-bit bit-length, as 16-word blocks over a valid/ready handshake.
module sha256_padder #(
  parameter int NUM_OF_WORDS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] message_addr,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic        word_last,
  output logic        msg_last,
  output logic        done
);

  localparam int NUM_BLOCKS = (NUM_OF_WORDS + 3 + 15) / 16;
  localparam int TOTAL_WORDS = 16 * NUM_BLOCKS;
  localparam int KW = 12;
  localparam logic [KW-1:0] N_K = KW'(NUM_OF_WORDS);
  localparam logic [KW-1:0] LAST_K = KW'(TOTAL_WORDS - 1);
  localparam logic [31:0] LEN_BITS = 32'(NUM_OF_WORDS * 32);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    EMIT
  } state_t;

  state_t        state_reg, state_next;
  logic [KW-1:0] k_reg, k_next;
  logic [15:0]   base_reg, base_next;
  logic [31:0]   data_reg, data_next;
  logic [KW-1:0] k_inc;
  logic          xfer;

  assign k_inc = k_reg + KW'(1);
  assign xfer  = word_valid && word_ready;

  // Generated (non-memory) words: the 0x80000000 marker, zero fill, and the
  // bit length in the final slot. The length high word is always zero.
  function automatic logic [31:0] pad_word(input logic [KW-1:0] idx);
    if (idx == N_K) begin
      return 32'h8000_0000;
    end else if (idx == LAST_K) begin
      return LEN_BITS;
    end
    return 32'h0000_0000;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      base_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      base_reg  <= base_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    base_next  = base_reg;
    data_next  = data_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          k_next     = '0;
          base_next  = message_addr;
        end
      end
      FETCH: state_next = WAIT;
      WAIT: begin
        state_next = EMIT;
        data_next  = mem_read_data;
      end
      EMIT: begin
        if (xfer) begin
          if (k_inc < N_K) begin
            state_next = FETCH;
            k_next     = k_inc;
            data_next  = '0;
          end else if (k_reg != LAST_K) begin
            k_next    = k_inc;
            data_next = pad_word(k_inc);
          end else begin
            state_next = IDLE;
            k_next     = '0;
            data_next  = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        k_next     = '0;
        data_next  = '0;
      end
    endcase
  end

  // In IDLE the address follows the live input so the memory is pre-pointed
  // at word 0 before start arrives.
  assign mem_addr   = (state_reg == IDLE) ? message_addr
                                          : base_reg + {{(16-KW){1'b0}}, k_reg};
  assign mem_clk    = clk;
  assign mem_we     = 1'b0;
  assign word_valid = (state_reg == EMIT);
  assign word_data  = data_reg;
  assign word_last  = word_valid && (k_reg[3:0] == 4'hF);
  assign msg_last   = word_valid && (k_reg == LAST_K);
  assign done       = (state_reg == IDLE);

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench: three padders (N=20,13,14) against a padding model built
// from the message-plus-marker-plus-zero-fill-plus-length rule.
module tb_sha256_padder;

  localparam int NS [3] = '{20, 13, 14};

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        m;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ready = 1'b1;
  logic [2:0]  start = 3'b000;
  logic [2:0]  valid, last, msg, done, we, mclk;
  logic [31:0] data  [3];
  logic [15:0] maddr [3];
  logic [15:0] base  [3];
  logic [31:0] rdata [3];

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          act = 0;
  int          xfer_cnt = 0;
  bit          rand_ready = 1'b0;
  logic [31:0] seed = 32'h1;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [15:0] a);
    return ({16'h0, a} * 32'h9E37_79B1) ^ seed;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      sha256_padder #(.NUM_OF_WORDS(NS[gi])) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start[gi]),
        .message_addr (base[gi]),
        .mem_clk      (mclk[gi]),
        .mem_we       (we[gi]),
        .mem_addr     (maddr[gi]),
        .mem_read_data(rdata[gi]),
        .word_valid   (valid[gi]),
        .word_ready   (ready),
        .word_data    (data[gi]),
        .word_last    (last[gi]),
        .msg_last     (msg[gi]),
        .done         (done[gi])
      );
      // Synchronous-read memory model
      always @(posedge mclk[gi]) rdata[gi] <= memf(maddr[gi]);
    end
  endgenerate

  // Ready changes just after each rising edge, so it is stable at the negedge sample.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: compares every transfer against the queue, and enforces stall
  // stability and zero data while not valid.
  initial begin : monitor
    logic        pend;
    logic [31:0] pd;
    logic        pl, pm;
    exp_t        e;
    pend = 1'b0; pd = '0; pl = 1'b0; pm = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          checks++;
          if (!valid[act] || data[act] != pd || last[act] != pl || msg[act] != pm) begin
            errors++;
            $display("FAIL stall_hold: valid=%0b data=%h last=%0b msg=%0b required valid=1 data=%h last=%0b msg=%0b",
                     valid[act], data[act], last[act], msg[act], pd, pl, pm);
          end
        end
        if (!valid[act]) begin
          checks++;
          if (data[act] != 32'h0) begin
            errors++;
            $display("FAIL idle_data: got %h required 00000000", data[act]);
          end
        end
        if (valid[act] && ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_word: got data=%h with no word expected", data[act]);
          end else begin
            e = exp_q.pop_front();
            if (data[act] != e.d || last[act] != e.l || msg[act] != e.m) begin
              errors++;
              $display("FAIL word[%0d] inst%0d: got data=%h last=%0b msg=%0b required data=%h last=%0b msg=%0b",
                       xfer_cnt, act, data[act], last[act], msg[act], e.d, e.l, e.m);
            end else begin
              $display("word[%0d] inst%0d data=%h last=%0b msg=%0b", xfer_cnt, act,
                       data[act], last[act], msg[act]);
            end
          end
          xfer_cnt++;
        end
        pend = valid[act] && !ready;
        pd = data[act]; pl = last[act]; pm = msg[act];
      end
    end
  end

  // Reference: message, 0x80000000, zeros up to 14 mod 16, then 64-bit length.
  task automatic build(input int n, input logic [15:0] a);
    logic [31:0] s[$];
    exp_t e;
    for (int k = 0; k < n; k++) s.push_back(memf(a + 16'(k)));
    s.push_back(32'h8000_0000);
    while (s.size() % 16 != 14) s.push_back(32'h0);
    s.push_back(32'h0);
    s.push_back(32'(n * 32));
    for (int idx = 0; idx < s.size(); idx++) begin
      e.d = s[idx];
      e.l = (idx % 16 == 15);
      e.m = (idx == s.size() - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic run(input int i, input logic [15:0] a, input bit rnd);
    int cnt;
    act = i;
    rand_ready = rnd;
    seed = $urandom;
    xfer_cnt = 0;
    base[i] = a;
    build(NS[i], a);
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
    cnt = 0;
    while (!(done[i] && exp_q.size() == 0) && cnt < 3000) begin
      @(posedge clk); #1;
      cnt++;
    end
    checks++;
    if (cnt >= 3000) begin
      errors++;
      $display("FAIL timeout inst%0d: %0d words left, done=%0b", i, exp_q.size(), done[i]);
      exp_q.delete();
    end
    checks++;
    if (done[i] !== 1'b1 || valid[i] !== 1'b0) begin
      errors++;
      $display("FAIL end_state inst%0d: done=%0b valid=%0b required done=1 valid=0", i, done[i], valid[i]);
    end
  endtask

  task automatic wait_xfers(input int n);
    int w;
    w = 0;
    while (xfer_cnt < n && w < 2000) begin
      @(posedge clk);
      w++;
    end
    checks++;
    if (w >= 2000) begin
      errors++;
      $display("FAIL xfer_wait: got %0d transfers required %0d", xfer_cnt, n);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) base[i] = 16'h1230 + 16'(i);
    #2;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (valid[i] || !done[i] || data[i] != 32'h0 || last[i] || msg[i] || we[i] || maddr[i] != base[i]) begin
        errors++;
        $display("FAIL reset_state inst%0d: valid=%0b done=%0b data=%h last=%0b msg=%0b we=%0b addr=%h required 0 1 0 0 0 0 addr=%h",
                 i, valid[i], done[i], data[i], last[i], msg[i], we[i], maddr[i], base[i]);
      end
    end
    #20 reset_n = 1'b1;

    run(0, 16'h0000, 1'b0);
    run(1, 16'($urandom), 1'b0);
    run(2, 16'($urandom), 1'b0);
    run(0, 16'h0000, 1'b1);
    run(1, 16'hFFFE, 1'b1);
    run(2, 16'($urandom), 1'b1);

    // Reset mid-stream, then restart from word 0.
    fork
      run(0, 16'($urandom), 1'b0);
      begin
        wait_xfers(5);
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        checks++;
        if (valid[0] || !done[0] || data[0] != 32'h0) begin
          errors++;
          $display("FAIL reset_abort: valid=%0b done=%0b data=%h required 0 1 00000000",
                   valid[0], done[0], data[0]);
        end
        exp_q.delete();
        #4 reset_n = 1'b1;
      end
    join
    run(0, 16'($urandom), 1'b0);

    // Start reasserted mid-stream with another address must be ignored.
    fork
      run(0, 16'h4000, 1'b0);
      begin
        wait_xfers(3);
        @(posedge clk); #1 base[0] = 16'h9999; start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0; base[0] = 16'h4000;
      end
    join

    for (int r = 0; r < 6; r++) run(r % 3, 16'($urandom), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
